stage_sequencer: RTL
====================

// Module: stage_sequencer
// PURPOSE
//  Multi-cycle instruction sequencer for the RV32IMF core: owns the 2-bit stage counter
//  consumed by the decoder/register-file enable logic (0 fetch, 1 decode/read,
//  2 execute, 3 writeback). Handshakes instruction memory, starts/waits on multi-cycle
//  units (M-extension mul/div, fixed-point), gates PC update, counts retired instructions.
// PARAMETERS
//  TIMEOUT_CYCLES  64  max EXECUTE wait cycles for exec_done before fatal halt (>=2)
//  COUNT_WIDTH     32  width of retired_count
// PORTS
//  clk              in   1   core clock, all state updates on rising edge
//  reset_n          in   1   asynchronous active-low reset
//  run              in   1   1 = fetch new instructions; 0 = stop after current instruction
//  imem_req         out  1   instruction fetch request
//  imem_ack         in   1   instruction word valid this cycle
//  ir_load          out  1   load instruction register (= imem_req & imem_ack)
//  multi_cycle      in   1   decoded op needs multi-cycle unit; valid in stage 1
//  exec_start       out  1   one-cycle start pulse to multi-cycle unit
//  exec_done        in   1   multi-cycle unit result ready
//  stage            out  2   current stage, to decoder enable logic
//  pc_write_enable  out  1   PC update strobe
//  busy             out  1   instruction in flight (stages 1..3, or fetch pending)
//  timeout_error    out  1   sticky: exec_done never arrived
//  retired_count    out  CW  retired instruction counter
// BEHAVIOUR
//  Reset (async, reset_n=0): state FETCH, stage=0, all strobes 0, timer 0, timeout_error 0,
//   retired_count 0. Release takes effect at next rising edge.
//  FSM states FETCH(0) DECODE(1) EXECUTE(2) WRITEBACK(3) HALT(stage=0); stage is registered.
//  FETCH: imem_req = run. Held high until imem_ack; ack with req low ignored.
//   On req&ack: ir_load=1 (same cycle), next DECODE. run=0 -> stay FETCH, busy=0.
//  DECODE: exactly 1 cycle; latch multi_cycle into mc_q; next EXECUTE.
//  EXECUTE: mc_q=0 -> 1 cycle, next WRITEBACK. mc_q=1 -> exec_start=1 on first cycle only;
//   exec_done sampled from 2nd EXECUTE cycle on (done in start cycle ignored);
//   done -> next WRITEBACK. Timer counts wait cycles from 2nd cycle; timer reaching
//   TIMEOUT_CYCLES without done -> HALT, timeout_error=1.
//  WRITEBACK: exactly 1 cycle; pc_write_enable=1; retired_count += 1 (wraps to 0 at max);
//   next FETCH. Timer cleared.
//  HALT: absorbing until reset; stage=0, imem_req/exec_start/pc_write_enable=0, busy=0.
//  run deassert mid-instruction: current instruction completes through WRITEBACK, then
//   FETCH idles. run reassert in FETCH issues imem_req same cycle (combinational on run).
//  Latency: no-stall single-cycle op = 4 cycles/instr; multi-cycle = 4 + wait cycles.
//  exec_done outside EXECUTE ignored. No output is X after reset.
// TESTING
//  1 reset, run=1, imem_ack=1 always, multi_cycle=0 -> stage 0,1,2,3 repeating;
//    pc_write_enable every 4th cycle; retired_count=5 after 20 cycles.
//  2 imem_ack delayed 3 cycles -> imem_req high 4 cycles, ir_load exactly 1 cycle, stage 0 held.
//  3 multi_cycle=1, exec_done 5 cycles after exec_start -> exec_start single pulse,
//    stage=2 for 6 cycles, then 3; also done in start cycle -> ignored, still waits.
//  4 TIMEOUT_CYCLES=8, exec_done never -> HALT after 9 EXECUTE cycles, timeout_error=1,
//    stays set with run=1 until reset_n pulse clears it.
//  5 run dropped during EXECUTE -> WRITEBACK completes, count+1, FETCH with imem_req=0.
//  6 reset_n low mid-EXECUTE (async, between edges) -> outputs reset immediately; COUNT_WIDTH=4
//    wrap: 16 retirements -> retired_count=0.

Source files
------------

// File: rtl/stage_sequencer.sv
// Multi-cycle instruction sequencer: fetch/decode/execute/writeback stage counter,
// imem handshake, multi-cycle unit start/wait with timeout, retired counter.
module stage_sequencer #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int COUNT_WIDTH    = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   run,
    output logic                   imem_req,
    input  logic                   imem_ack,
    output logic                   ir_load,
    input  logic                   multi_cycle,
    output logic                   exec_start,
    input  logic                   exec_done,
    output logic [1:0]             stage,
    output logic                   pc_write_enable,
    output logic                   busy,
    output logic                   timeout_error,
    output logic [COUNT_WIDTH-1:0] retired_count
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_t;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    logic [TW-1:0] timer;
    logic          mc_q;

    assign imem_req = (state == S_FETCH) && run;
    assign ir_load  = imem_req && imem_ack;
    assign busy     = imem_req
                   || (state == S_DECODE)
                   || (state == S_EXECUTE)
                   || (state == S_WRITEBACK);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= S_FETCH;
            stage           <= 2'd0;
            exec_start      <= 1'b0;
            pc_write_enable <= 1'b0;
            timer           <= '0;
            mc_q            <= 1'b0;
            timeout_error   <= 1'b0;
            retired_count   <= '0;
        end else begin
            exec_start      <= 1'b0;
            pc_write_enable <= 1'b0;
            unique case (state)
                S_FETCH: begin
                    if (run && imem_ack) begin
                        state <= S_DECODE;
                        stage <= 2'd1;
                    end
                end
                S_DECODE: begin
                    mc_q       <= multi_cycle;
                    exec_start <= multi_cycle;
                    timer      <= '0;
                    state      <= S_EXECUTE;
                    stage      <= 2'd2;
                end
                S_EXECUTE: begin
                    // exec_start is high only in the first EXECUTE cycle,
                    // so it doubles as the "ignore exec_done" marker
                    if (!mc_q || (!exec_start && exec_done)) begin
                        state           <= S_WRITEBACK;
                        stage           <= 2'd3;
                        pc_write_enable <= 1'b1;
                    end else if (!exec_start) begin
                        if (timer == TMAX) begin
                            state         <= S_HALT;
                            stage         <= 2'd0;
                            timeout_error <= 1'b1;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                end
                S_WRITEBACK: begin
                    retired_count <= retired_count + COUNT_WIDTH'(1);
                    timer         <= '0;
                    state         <= S_FETCH;
                    stage         <= 2'd0;
                end
                S_HALT: begin
                    state <= S_HALT;
                    stage <= 2'd0;
                end
                default: begin
                    state <= S_HALT;
                    stage <= 2'd0;
                end
            endcase
        end
    end

endmodule
